// File: rtl/decode_stage_if.sv
// Decode-stage bus: instruction handshake in, writeback in, ID/EX operands out.
interface decode_stage_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
);
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ex_ready;
  logic              valid_ex;
  logic [5:0]        op_dec;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [AW-1:0]     rd_ex;

  modport master (
    output instr, instr_valid, wb_en, wb_addr, wb_data, ex_ready,
    input  instr_ready, valid_ex, op_dec, A, B, rd_ex
  );
  modport slave (
    input  instr, instr_valid, wb_en, wb_addr, wb_data, ex_ready,
    output instr_ready, valid_ex, op_dec, A, B, rd_ex
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode: register file with writeback bypass, RAW scoreboard,
// and the ID/EX pipeline register feeding the ALU.
module decode_stage #(
  parameter int         DATA_W  = 16,
  parameter int         NREGS   = 8,
  parameter logic [5:0] NOP_OPC = 6'b111111
) (
  input  logic         clk,
  input  logic         reset,
  decode_stage_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef struct packed {
    logic [5:0]        opc;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } ex_op_t;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend, pend_nxt;
  logic              valid_q;
  ex_op_t            ex_q, ex_d;

  logic [5:0]        opc;
  logic              is_i, is_nop;
  logic [AW-1:0]     rd, rs, rt, src_a;
  logic              hz_a, hz_b, hazard, accept;
  logic              unused_bit;

  assign opc        = bus.instr[15:10];
  assign is_i       = bus.instr[15];
  assign is_nop     = (opc == NOP_OPC);
  assign rd         = bus.instr[9:7];
  assign rs         = bus.instr[6:4];
  assign rt         = bus.instr[3:1];
  assign unused_bit = bus.instr[0];
  // I-type reads its destination as operand A
  assign src_a      = is_i ? rd : rs;

  // A pending source is fine if its writeback lands this very cycle
  assign hz_a   = (src_a != '0) && pend[src_a] && !(bus.wb_en && bus.wb_addr == src_a);
  assign hz_b   = !is_i && (rt != '0) && pend[rt] && !(bus.wb_en && bus.wb_addr == rt);
  assign hazard = !is_nop && (hz_a || hz_b);

  assign bus.instr_ready = !reset && !hazard && (!valid_q || bus.ex_ready);
  assign accept          = bus.instr_valid && bus.instr_ready;

  always_comb begin
    ex_d     = '0;
    ex_d.opc = opc;
    ex_d.rd  = rd;
    if (src_a == '0)                                ex_d.a = '0;
    else if (bus.wb_en && bus.wb_addr == src_a)     ex_d.a = bus.wb_data;
    else                                            ex_d.a = regs[src_a];
    if (is_i)                                       ex_d.b = {{(DATA_W-7){bus.instr[6]}}, bus.instr[6:0]};
    else if (rt == '0)                              ex_d.b = '0;
    else if (bus.wb_en && bus.wb_addr == rt)        ex_d.b = bus.wb_data;
    else                                            ex_d.b = regs[rt];
  end

  // Clear on writeback first so a same-cycle reissue of that rd re-sets it
  always_comb begin
    pend_nxt = pend;
    if (bus.wb_en) pend_nxt[bus.wb_addr] = 1'b0;
    if (accept && !is_nop && rd != '0) pend_nxt[rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      if (bus.wb_en && bus.wb_addr != '0) regs[bus.wb_addr] <= bus.wb_data;
      pend <= pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else if (accept) begin
      valid_q <= !is_nop;
      if (!is_nop) ex_q <= ex_d;
    end else if (bus.ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.valid_ex = valid_q;
  assign bus.op_dec   = ex_q.opc;
  assign bus.A        = ex_q.a;
  assign bus.B        = ex_q.b;
  assign bus.rd_ex    = ex_q.rd;
endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized bench for decode_stage against a behavioural model.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_stage_if bus();
  decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [8];
  logic [7:0]  m_pend;
  logic        m_v;
  logic [5:0]  m_op;
  logic [15:0] m_a, m_b;
  logic [2:0]  m_rd;
  bit          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] r_ins(input logic [5:0] opc, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {opc, rd, rs, rt, 1'b0};
  endfunction

  function automatic logic [15:0] i_ins(input logic [5:0] opc, input logic [2:0] rd,
                                        input logic [6:0] imm);
    return {opc, rd, imm};
  endfunction

  // Architectural read seen by an instruction this cycle
  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  task automatic step();
    logic [15:0] ins;
    logic [5:0]  opc;
    logic [2:0]  rd, rs, rt;
    logic [2:0]  srcs[$];
    logic [15:0] a, b;
    bit nop, ity, hz, rdy, acc;
    #2;
    ins = bus.instr;
    opc = ins[15:10];
    rd = ins[9:7]; rs = ins[6:4]; rt = ins[3:1];
    ity = ins[15];
    nop = (opc == 6'h3F);
    srcs = {};
    if (!nop) begin
      if (ity) srcs.push_back(rd);
      else begin srcs.push_back(rs); srcs.push_back(rt); end
    end
    hz = 0;
    foreach (srcs[k])
      if (srcs[k] != 0 && m_pend[srcs[k]] && !(bus.wb_en && bus.wb_addr == srcs[k])) hz = 1;
    rdy = !reset && !hz && (!m_v || bus.ex_ready);
    chk("instr_ready", {31'd0, bus.instr_ready}, {31'd0, rdy});
    acc = bus.instr_valid && rdy;
    last_acc = acc;
    a = ity ? m_read(rd) : m_read(rs);
    b = ity ? {{9{ins[6]}}, ins[6:0]} : m_read(rt);
    @(posedge clk);
    if (reset) begin
      foreach (m_regs[k]) m_regs[k] = 16'h0;
      m_pend = 8'h0; m_v = 0; m_op = 0; m_a = 0; m_b = 0; m_rd = 0;
    end else begin
      if (bus.wb_en && bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
      if (bus.wb_en) m_pend[bus.wb_addr] = 1'b0;
      if (acc && !nop && rd != 0) m_pend[rd] = 1'b1;
      if (acc) begin
        m_v = !nop;
        if (!nop) begin m_op = opc; m_a = a; m_b = b; m_rd = rd; end
      end else if (bus.ex_ready) m_v = 0;
    end
    #1;
    chk("valid_ex", {31'd0, bus.valid_ex}, {31'd0, m_v});
    chk("op_dec", {26'd0, bus.op_dec}, {26'd0, m_op});
    chk("A", {16'd0, bus.A}, {16'd0, m_a});
    chk("B", {16'd0, bus.B}, {16'd0, m_b});
    chk("rd_ex", {29'd0, bus.rd_ex}, {29'd0, m_rd});
    chk("pend", {24'd0, dut.pend}, {24'd0, m_pend});
  endtask

  task automatic drive(input bit rst, input bit iv, input logic [15:0] ins,
                       input bit wbe, input logic [2:0] wa, input logic [15:0] wd,
                       input bit exr);
    reset = rst;
    bus.instr_valid = iv; bus.instr = ins;
    bus.wb_en = wbe; bus.wb_addr = wa; bus.wb_data = wd;
    bus.ex_ready = exr;
    step();
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] cur_ins;
    bit cur_iv;
    foreach (m_regs[k]) m_regs[k] = 16'h0;
    m_pend = 0; m_v = 0; m_op = 0; m_a = 0; m_b = 0; m_rd = 0;
    last_acc = 0;

    // Reset, with writeback and instr attempted under reset
    drive(1, 1, r_ins(6'h01, 1, 2, 3), 1, 3'd5, 16'hBEEF, 1);
    drive(1, 1, r_ins(6'h01, 1, 2, 3), 1, 3'd5, 16'hBEEF, 1);
    chk("rst_valid", {31'd0, bus.valid_ex}, 32'd0);

    // 1: first op
    drive(0, 1, r_ins(6'h01, 1, 2, 3), 0, 0, 0, 1);
    chk("t1_valid", {31'd0, bus.valid_ex}, 32'd1);
    chk("t1_op", {26'd0, bus.op_dec}, 32'h01);
    chk("t1_A", {16'd0, bus.A}, 32'h0);
    chk("t1_rd", {29'd0, bus.rd_ex}, 32'd1);
    drive(0, 0, 16'h0, 1, 3'd1, 16'h0001, 1);

    // 2: same-cycle bypass
    drive(0, 1, r_ins(6'h03, 4, 2, 2), 1, 3'd2, 16'h4000, 1);
    chk("t2_A", {16'd0, bus.A}, 32'h4000);
    chk("t2_B", {16'd0, bus.B}, 32'h4000);
    drive(0, 1, r_ins(6'h01, 0, 2, 0), 1, 3'd4, 16'h0044, 1);
    chk("t2_later", {16'd0, bus.A}, 32'h4000);

    // 3: RAW stall released by writeback, reissued rd stays pending
    drive(0, 1, r_ins(6'h02, 3, 1, 1), 0, 0, 0, 1);
    drive(0, 1, r_ins(6'h01, 3, 3, 0), 0, 0, 0, 1);
    drive(0, 1, r_ins(6'h01, 3, 3, 0), 0, 0, 0, 1);
    chk("t3_stalled", {31'd0, bus.valid_ex}, 32'd0);
    drive(0, 1, r_ins(6'h01, 3, 3, 0), 1, 3'd3, 16'hC000, 1);
    chk("t3_A", {16'd0, bus.A}, 32'hC000);
    chk("t3_pend3", {31'd0, dut.pend[3]}, 32'd1);
    drive(0, 0, 16'h0, 1, 3'd3, 16'hC000, 1);

    // 4: backpressure
    drive(0, 1, r_ins(6'h04, 2, 1, 2), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, r_ins(6'h05, 6, 1, 1), 0, 0, 0, 0);
      chk("t4_hold_op", {26'd0, bus.op_dec}, 32'h04);
    end
    drive(0, 1, r_ins(6'h05, 6, 1, 1), 0, 0, 0, 1);
    chk("t4_release", {26'd0, bus.op_dec}, 32'h05);
    drive(0, 0, 16'h0, 1, 3'd2, 16'h4000, 1);
    drive(0, 0, 16'h0, 1, 3'd6, 16'h0066, 1);

    // 5: I-type sign extension, R0 behaviour
    drive(0, 1, i_ins(6'h20, 1, 7'h7F), 0, 0, 0, 1);
    chk("t5_A", {16'd0, bus.A}, 32'h0001);
    chk("t5_B", {16'd0, bus.B}, 32'hFFFF);
    drive(0, 0, 16'h0, 1, 3'd1, 16'h0001, 1);
    drive(0, 0, 16'h0, 1, 3'd0, 16'h1234, 1);
    drive(0, 1, r_ins(6'h01, 4, 0, 0), 0, 0, 0, 1);
    chk("t5_r0", {16'd0, bus.A}, 32'h0);
    chk("t5_r0_valid", {31'd0, bus.valid_ex}, 32'd1);
    drive(0, 0, 16'h0, 1, 3'd4, 16'h0044, 1);

    // 6: NOP bubble, then reset during a stall
    drive(0, 1, 16'hFEA5, 0, 0, 0, 1);
    chk("t6_nop_valid", {31'd0, bus.valid_ex}, 32'd0);
    chk("t6_nop_pend", {24'd0, dut.pend}, 32'h0);
    drive(0, 1, r_ins(6'h01, 5, 2, 0), 0, 0, 0, 1);
    drive(0, 0, 16'h0, 0, 0, 0, 0);
    drive(1, 1, r_ins(6'h01, 6, 1, 1), 1, 3'd5, 16'h5555, 0);
    chk("t6_rst_valid", {31'd0, bus.valid_ex}, 32'd0);
    chk("t6_rst_A", {16'd0, bus.A}, 32'h0);
    chk("t6_rst_pend", {24'd0, dut.pend}, 32'h0);
    drive(0, 1, r_ins(6'h01, 0, 2, 2), 0, 0, 0, 1);
    chk("t6_regs_cleared", {16'd0, bus.A}, 32'h0);

    // Randomized traffic; upstream holds an unaccepted instr
    cur_ins = 16'h0; cur_iv = 0;
    for (int i = 0; i < 400; i++) begin
      if (last_acc || !cur_iv) begin
        r = $urandom;
        cur_ins = ($urandom_range(0, 9) == 0) ? {6'h3F, r[9:0]} : r[15:0];
      end
      cur_iv = ($urandom_range(0, 3) != 0);
      r = $urandom;
      drive(($urandom_range(0, 63) == 0), cur_iv, cur_ins,
            ($urandom_range(0, 1) == 1), r[18:16], r[15:0],
            ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
